// File: rtl/game_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_ctrl_if
// Groups the signals between the single-player pong graphics stage and the
// game supervisor into one bundle.
//
// Signals:
//   frame_tick  one-cycle pulse per video frame
//   start       level, any player button
//   hit         bar-hit strobe from the graphics stage
//   miss        player-miss strobe from the graphics stage
//   score[3:0]  current score
//   ball[1:0]   balls remaining
//   still       1 = motion frozen
//   serve       one-cycle pulse on entry to play
//   state[1:0]  0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER
//
// Modports:
//   master  graphics / stimulus side (drives strobes, reads game status)
//   slave   game supervisor side (reads strobes, drives game status)
// ---------------------------------------------------------------------------
interface game_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       hit;
  logic       miss;
  logic [3:0] score;
  logic [1:0] ball;
  logic       still;
  logic       serve;
  logic [1:0] state;

  modport master (
    output frame_tick, start, hit, miss,
    input  score, ball, still, serve, state
  );

  modport slave (
    input  frame_tick, start, hit, miss,
    output score, ball, still, serve, state
  );
endinterface

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
// Single-player game supervisor sitting behind the pong graphics stage.
// Turns hit/miss strobes into score and ball counts and sequences the game
// through NEWGAME -> PLAY -> NEWBALL/OVER. Every output is registered.
//
// Ports:
//   clk   in   system clock, same domain as the graphics stage
//   rst   in   asynchronous, active-low reset
//   gif   slave side of game_ctrl_if
//           inputs : frame_tick, start, hit, miss
//           outputs: score[3:0], ball[1:0], still, serve, state[1:0]
// ---------------------------------------------------------------------------
module game_ctrl #(
  parameter int BALLS_INIT   = 3,
  parameter int SCORE_MAX    = 11,
  parameter int SERVE_FRAMES = 120,
  parameter int HIT_HOLDOFF  = 8
) (
  input  logic       clk,
  input  logic       rst,
  game_ctrl_if.slave gif
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_e;

  localparam logic [1:0] BALLS_LOAD   = 2'(BALLS_INIT);
  localparam logic [4:0] SCORE_LIMIT  = 5'(SCORE_MAX);
  localparam logic [6:0] SERVE_LOAD   = 7'(SERVE_FRAMES);
  localparam logic [3:0] HOLDOFF_LOAD = 4'(HIT_HOLDOFF);

  state_e     state_q, state_d;
  logic [3:0] score_q, score_d;
  logic [1:0] ball_q, ball_d;
  logic [6:0] timer_q, timer_d;
  logic [3:0] holdoff_q, holdoff_d;
  logic       hit_r, miss_r;
  logic       serve_q, serve_d;
  logic       still_q, still_d;
  logic       hit_ev, miss_ev;
  logic [3:0] score_inc;

  // One event per rising edge, however long the strobe stays high.
  assign hit_ev  = gif.hit  & ~hit_r;
  assign miss_ev = gif.miss & ~miss_r;

  // State and counter registers; edge-detect copies update in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= NEWGAME;
      score_q   <= 4'd0;
      ball_q    <= BALLS_LOAD;
      timer_q   <= 7'd0;
      holdoff_q <= 4'd0;
      hit_r     <= 1'b0;
      miss_r    <= 1'b0;
      serve_q   <= 1'b0;
      still_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      ball_q    <= ball_d;
      timer_q   <= timer_d;
      holdoff_q <= holdoff_d;
      hit_r     <= gif.hit;
      miss_r    <= gif.miss;
      serve_q   <= serve_d;
      still_q   <= still_d;
    end
  end

  // Next-state logic. A miss always wins over a simultaneous hit. Timer
  // and holdoff only count down while nonzero, so they never wrap.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    ball_d    = ball_q;
    timer_d   = timer_q;
    holdoff_d = holdoff_q;
    score_inc = (score_q == 4'd15) ? 4'd15 : score_q + 4'd1;

    case (state_q)
      NEWGAME: begin
        score_d = 4'd0;
        ball_d  = BALLS_LOAD;
        if (gif.start) state_d = PLAY;
      end

      PLAY: begin
        if (gif.frame_tick && holdoff_q != 4'd0) holdoff_d = holdoff_q - 4'd1;
        if (miss_ev) begin
          ball_d  = ball_q - 2'd1;
          timer_d = SERVE_LOAD;
          state_d = (ball_q == 2'd1) ? OVER : NEWBALL;
        end else if (hit_ev && holdoff_q == 4'd0) begin
          score_d   = score_inc;
          holdoff_d = HOLDOFF_LOAD;
          if ({1'b0, score_inc} > SCORE_LIMIT) begin
            state_d = OVER;
            timer_d = SERVE_LOAD;
          end
        end
      end

      NEWBALL: begin
        if (timer_q == 7'd0) begin
          if (gif.start) state_d = PLAY;
        end else if (gif.frame_tick) begin
          timer_d = timer_q - 7'd1;
        end
      end

      OVER: begin
        if (timer_q == 7'd0) begin
          state_d = NEWGAME;
          score_d = 4'd0;
          ball_d  = BALLS_LOAD;
        end else if (gif.frame_tick) begin
          timer_d = timer_q - 7'd1;
        end
      end

      default: state_d = NEWGAME;
    endcase

    // Serve marks the first cycle of PLAY; freeze everywhere else.
    serve_d = (state_d == PLAY) && (state_q != PLAY);
    still_d = (state_d != PLAY);
  end

  assign gif.state = state_q;
  assign gif.score = score_q;
  assign gif.ball  = ball_q;
  assign gif.still = still_q;
  assign gif.serve = serve_q;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Single-player game supervisor, directly downstream of the single-player pong graphics stage.
- Consumes that stage's hit/miss strobes and produces its score[3:0] and ball[1:0] inputs.
- Sequences the game through new-game, play, serve-delay and game-over states.
- Drives a freeze flag and a serve pulse used by the graphics stage and the text overlay.

Parameters:
- BALLS_INIT, 3, balls (lives) loaded at new game; must be 1..3.
- SCORE_MAX, 11, game over once score exceeds this value.
- SERVE_FRAMES, 120, frame ticks waited in NEWBALL and OVER (2 s at 60 Hz); 1..127.
- HIT_HOLDOFF, 8, frame ticks during which further hits are ignored after an accepted hit; 1..15.

Ports:
- clk  in  1  system clock, same domain as graphics stage.
- rst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (pixel_y==500 && pixel_x==0).
- start  in  1  level; any player button (up1|down1), OR-ed externally.
- hit  in  1  bar-hit strobe from graphics stage; may stay high for several cycles.
- miss  in  1  player-miss strobe from graphics stage; may stay high for several cycles.
- score  out  4  current score, binary.
- ball  out  2  balls remaining.
- still  out  1  1 = ball/bar motion frozen (every state except PLAY).
- serve  out  1  one-cycle pulse on entry to PLAY.
- state  out  2  0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER.

Behaviour:
- Reset (rst=0, async):
  - state=NEWGAME, score=0, ball=BALLS_INIT, still=1, serve=0.
  - timer=0, holdoff=0, edge-detect registers=0.
  - Takes effect mid-game too, with no residue.
- Edge detect:
  - hit_r and miss_r are registered copies of the inputs.
  - Event = input & ~registered copy, i.e. one event per rising edge regardless of pulse length.
- NEWGAME:
  - still=1; score held at 0, ball held at BALLS_INIT.
  - start==1 → PLAY, with serve=1 on the transition cycle.
- PLAY (still=0):
  - Accepted hit:
    - Requires a hit event and holdoff==0.
    - score ← score+1, saturating at 15.
    - holdoff ← HIT_HOLDOFF.
  - holdoff decrements by 1 on each frame_tick while nonzero.
  - Miss event:
    - ball ← ball−1.
    - If the old ball==1, go to OVER; otherwise go to NEWBALL.
    - Either way, timer ← SERVE_FRAMES.
  - Hit and miss events in the same cycle: miss is processed, hit is discarded, score unchanged.
  - If score after the increment is > SCORE_MAX: go to OVER, timer ← SERVE_FRAMES. This has priority over staying in PLAY.
  - Events outside PLAY are ignored; the edge registers still update.
- NEWBALL:
  - still=1; timer decrements on each frame_tick.
  - When timer==0 and start==1: go to PLAY, serve=1.
  - start held high during the countdown → serve occurs on the first cycle timer==0.
- OVER:
  - still=1; timer decrements on each frame_tick.
  - At timer==0: go to NEWGAME, and reset score=0, ball=BALLS_INIT in that same cycle.
- Arithmetic: timer is 7 bits and holdoff is 4 bits; neither underflows below 0.
- All outputs are registered; outputs change one cycle after the causing input edge.
- The graphics stage's over = (score>11 || ball==0) must agree with state==OVER, one cycle later at most.

Test Plan:
1. Release reset, hold start=0 for 100 cycles → state=0, score=0, ball=3, still=1, serve never 1. Then start=1 for 1 cycle → next cycle state=1, serve=1 for exactly one cycle, still=0.
2. In PLAY, hold hit high for 5 cycles → score 0→1 only. Pulse hit again before 8 frame_ticks → score stays 1. Pulse after 8 frame_ticks → score=2.
3. In PLAY with ball=3, pulse miss → ball=2, state=2, still=1. Apply 120 frame_ticks with start=1 → state=1 with serve pulse on the cycle timer reaches 0.
4. Three misses separated by serves → ball=0 and state=3. After 120 frame_ticks → state=0, score=0, ball=3.
5. Score 11, issue accepted hit → score=12, state=3 next cycle. Separately, assert hit and miss in the same cycle → score unchanged, ball decremented.
6. Assert rst=0 asynchronously mid-NEWBALL with timer=50 → outputs return to reset values immediately with no clock edge. Release → state=0.
